// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface mc_controller_if;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        PC_En;
  logic        IR_En;
  logic        Reg_Write;
  logic        Mem_Write;
  logic        ALU_Sel;
  logic        Mem_To_Reg;
  logic        Reg_Dst;
  logic        Branch;
  logic        Ext_Op;
  logic        Jal_Sel;
  logic        Jr_Sel;
  logic        Byte;
  logic        Half;
  logic [3:0]  ALU_Ctr;
  logic [2:0]  State;
  logic [31:0] Retired;
  logic        Halt;

  modport master (
    input  Op, Funct, Zero,
    output PC_En, IR_En, Reg_Write, Mem_Write,
    output ALU_Sel, Mem_To_Reg, Reg_Dst, Branch,
    output Ext_Op, Jal_Sel, Jr_Sel, Byte, Half,
    output ALU_Ctr, State, Retired, Halt
  );

  modport slave (
    output Op, Funct, Zero,
    input  PC_En, IR_En, Reg_Write, Mem_Write,
    input  ALU_Sel, Mem_To_Reg, Reg_Dst, Branch,
    input  Ext_Op, Jal_Sel, Jr_Sel, Byte, Half,
    input  ALU_Ctr, State, Retired, Halt
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control sequencer: fetch/decode/exec/mem/wb strobes.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unrecognised op halts instead of nop.
module mc_controller (
  input logic clk,
  input logic reset,
  mc_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,S_HALT  = 3'd5
`endif
  } state_t;

  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_SUB = 4'd1;
  localparam logic [3:0] C_OR  = 4'd2;
  localparam logic [3:0] C_LUI = 4'd3;
  localparam logic [3:0] C_SLL = 4'd4;

  state_t      state;
  logic [31:0] retired;

  logic [5:0] op;
  logic [5:0] fn;
  assign op = bus.Op;
  assign fn = bus.Funct;

  // Zero is consumed by the NPC, not here.
  logic unused_zero;
  assign unused_zero = bus.Zero;

  logic r_add, r_sub, r_sll, r_alu, jr_i;
  logic ori_i, lui_i, beq_i, jal_i;
  logic lw_i, lb_i, lh_i, sw_i, sb_i, sh_i;
  logic load, store, to_wb, exec_last, known;

  assign r_add = op == 6'd0 &&
                 (fn == 6'b100000 || fn == 6'b100001);
  assign r_sub = op == 6'd0 &&
                 (fn == 6'b100010 || fn == 6'b100011);
  assign r_sll = op == 6'd0 && fn == 6'b000000;
  assign r_alu = r_add | r_sub | r_sll;
  assign jr_i  = op == 6'd0 && fn == 6'b001000;

  assign ori_i = op == 6'b001101;
  assign lui_i = op == 6'b001111;
  assign beq_i = op == 6'b000100;
  assign jal_i = op == 6'b000011;
  assign lw_i  = op == 6'b100011;
  assign lb_i  = op == 6'b100000;
  assign lh_i  = op == 6'b100001;
  assign sw_i  = op == 6'b101011;
  assign sb_i  = op == 6'b101000;
  assign sh_i  = op == 6'b101001;

  assign load      = lw_i | lb_i | lh_i;
  assign store     = sw_i | sb_i | sh_i;
  assign to_wb     = r_alu | ori_i | lui_i;
  assign exec_last = beq_i | jal_i | jr_i;
  assign known     = to_wb | load | store | exec_last;

  assign bus.ALU_Sel    = ori_i | lui_i | load | store;
  assign bus.Mem_To_Reg = load;
  assign bus.Reg_Dst    = r_alu;
  assign bus.Branch     = beq_i;
  assign bus.Ext_Op     = load | store | beq_i;
  assign bus.Jal_Sel    = jal_i;
  assign bus.Jr_Sel     = jr_i;
  assign bus.Byte       = lb_i | sb_i;
  assign bus.Half       = lh_i | sh_i;

  always_comb begin
    bus.ALU_Ctr = C_ADD;
    unique case (1'b1)
      r_sub | beq_i: bus.ALU_Ctr = C_SUB;
      ori_i:         bus.ALU_Ctr = C_OR;
      lui_i:         bus.ALU_Ctr = C_LUI;
      r_sll:         bus.ALU_Ctr = C_SLL;
      default:       bus.ALU_Ctr = C_ADD;
    endcase
  end

  logic pc_en, ir_en, reg_wr, mem_wr;

  // Reset masks everything, including IR_En while parked in FETCH.
  always_comb begin
    pc_en  = 1'b0;
    ir_en  = 1'b0;
    reg_wr = 1'b0;
    mem_wr = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: ir_en = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_DECODE: pc_en = 1'b0;
`else
        S_DECODE: pc_en = !known;
`endif
        S_EXEC: begin
          pc_en  = exec_last;
          reg_wr = jal_i;
        end
        S_MEM: begin
          pc_en  = store;
          mem_wr = store;
        end
        S_WB: begin
          pc_en  = to_wb | load;
          reg_wr = to_wb | load;
        end
        default: ;
      endcase
    end
  end

  assign bus.PC_En     = pc_en;
  assign bus.IR_En     = ir_en;
  assign bus.Reg_Write = reg_wr;
  assign bus.Mem_Write = mem_wr;
  assign bus.State     = state;
  assign bus.Retired   = retired;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.Halt = state == S_HALT;
`else
  assign bus.Halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      if (pc_en)
        retired <= retired + 32'd1;
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (known)
            state <= S_EXEC;
          else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state <= S_HALT;
`else
            state <= S_FETCH;
`endif
        end
        S_EXEC: begin
          if (load | store)
            state <= S_MEM;
          else if (to_wb)
            state <= S_WB;
          else
            state <= S_FETCH;
        end
        S_MEM: state <= load ? S_WB : S_FETCH;
        S_WB:  state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: state walks, strobes, selects, reset.
// Strobe vector {PC_En,IR_En,Reg_Write,Mem_Write}; select vector ends in ALU_Ctr.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ret = 0;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0]  strb;
  logic [12:0] sel;
  assign strb = {bus.PC_En, bus.IR_En, bus.Reg_Write, bus.Mem_Write};
  assign sel  = {bus.ALU_Sel, bus.Mem_To_Reg, bus.Reg_Dst, bus.Branch,
                 bus.Ext_Op, bus.Jal_Sel, bus.Jr_Sel, bus.Byte, bus.Half,
                 bus.ALU_Ctr};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a sample point inside FETCH; returns at the next FETCH.
  task automatic do_instr(input string tag, input logic [5:0] op,
                          input logic [5:0] fn, input int n,
                          input logic [14:0] st, input logic [19:0] sb,
                          input logic [12:0] sl);
    bus.Op = op;
    bus.Funct = fn;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s st%0d", tag, c), 32'(bus.State),
          32'(st[c*3 +: 3]));
      chk($sformatf("%s strb%0d", tag, c), 32'(strb),
          32'(sb[c*4 +: 4]));
      if (c == 1)
        chk({tag, " sel"}, 32'(sel), 32'(sl));
      @(posedge clk);
      #1;
    end
    exp_ret++;
    chk({tag, " retired"}, bus.Retired, exp_ret);
    chk({tag, " back"}, 32'(bus.State), 32'd0);
  endtask

  localparam logic [14:0] ST_WB  = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] ST_LD  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] ST_ST  = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] ST_EX  = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
  localparam logic [19:0] SB_WB  = {4'h0, 4'b1010, 4'h0, 4'h0, 4'b0100};
  localparam logic [19:0] SB_LD  = {4'b1010, 4'h0, 4'h0, 4'h0, 4'b0100};
  localparam logic [19:0] SB_ST  = {4'h0, 4'b1001, 4'h0, 4'h0, 4'b0100};
  localparam logic [19:0] SB_BR  = {4'h0, 4'h0, 4'b1000, 4'h0, 4'b0100};
  localparam logic [19:0] SB_JAL = {4'h0, 4'h0, 4'b1010, 4'h0, 4'b0100};

  initial begin
    bus.Op = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero = 1'b0;
    #1;
    chk("rst state", 32'(bus.State), 32'd0);
    chk("rst strb", 32'(strb), 32'd0);
    chk("rst retired", bus.Retired, 32'd0);
    chk("rst halt", 32'(bus.Halt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first ir_en", 32'(bus.IR_En), 32'd1);

    do_instr("addu", 6'h00, 6'h21, 4, ST_WB, SB_WB, 13'b0010000000000);
    do_instr("lw", 6'h23, 6'h00, 5, ST_LD, SB_LD, 13'b1100100000000);
    do_instr("sb", 6'h28, 6'h00, 4, ST_ST, SB_ST, 13'b1000100100000);
    do_instr("beq", 6'h04, 6'h00, 3, ST_EX, SB_BR, 13'b0001100000001);
    do_instr("jal", 6'h03, 6'h00, 3, ST_EX, SB_JAL, 13'b0000010000000);
    do_instr("jr", 6'h00, 6'h08, 3, ST_EX, SB_BR, 13'b0000001000000);
    do_instr("ori", 6'h0D, 6'h00, 4, ST_WB, SB_WB, 13'b1000000000010);
    do_instr("lui", 6'h0F, 6'h00, 4, ST_WB, SB_WB, 13'b1000000000011);
    do_instr("sll", 6'h00, 6'h00, 4, ST_WB, SB_WB, 13'b0010000000100);
    do_instr("sub", 6'h00, 6'h22, 4, ST_WB, SB_WB, 13'b0010000000001);
    do_instr("lh", 6'h21, 6'h00, 5, ST_LD, SB_LD, 13'b1100100010000);
    do_instr("sh", 6'h29, 6'h00, 4, ST_ST, SB_ST, 13'b1000100010000);

    // Abandon an addu in EXEC.
    bus.Op = 6'h00;
    bus.Funct = 6'h21;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid exec", 32'(bus.State), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid rst state", 32'(bus.State), 32'd0);
    chk("mid rst retired", bus.Retired, 32'd0);
    chk("mid rst strb", 32'(strb), 32'd0);
    @(posedge clk);
    #1;
    chk("mid rst hold", 32'(strb), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
    #1;
    chk("rel ir_en", 32'(bus.IR_En), 32'd1);
    do_instr("addu2", 6'h00, 6'h21, 4, ST_WB, SB_WB, 13'b0010000000000);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    bus.Op = 6'h3F;
    bus.Funct = 6'h00;
    @(posedge clk);
    #1;
    chk("ill decode", 32'(bus.State), 32'd1);
    chk("ill dec strb", 32'(strb), 32'd0);
    @(posedge clk);
    #1;
    chk("ill halt st", 32'(bus.State), 32'd5);
    chk("ill halt", 32'(bus.Halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("halt strb%0d", i), 32'(strb), 32'd0);
    end
    chk("halt st end", 32'(bus.State), 32'd5);
    chk("halt retired", bus.Retired, exp_ret);
`else
    do_instr("nop", 6'h3F, 6'h00, 2, ST_EX,
             {4'h0, 4'h0, 4'h0, 4'b1000, 4'b0100}, 13'd0);
    do_instr("nop0", 6'h00, 6'h3F, 2, ST_EX,
             {4'h0, 4'h0, 4'h0, 4'b1000, 4'b0100}, 13'd0);
    chk("nop halt", 32'(bus.Halt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
